// File: rtl/uart_hex_fmt.sv
// rtl/uart_hex_fmt.sv - formats 16-bit samples as ASCII hex lines for a UART transmitter
// Samples queue in a small FIFO; a 4-state FSM emits one hex line per sample.
module uart_hex_fmt #(
   parameter int FIFO_DEPTH = 4,
   parameter bit EOL_CRLF   = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [15:0] sample_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        send_o,
   output logic [7:0]  data_o,
   input  logic        ready_i,
   output logic        busy_o,
   output logic        overflow_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] SEND = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   localparam logic [2:0] LAST_IDX = EOL_CRLF ? 3'd5 : 3'd4;

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic [15:0]   line_q, line_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          send_q, send_d;
   logic [7:0]    data_q, data_d;
   logic          ovf_q, ovf_d;

   logic          push;
   logic          pop;
   logic [3:0]    nib;
   logic [7:0]    char;

   assign ready_o    = (count_q != CW'(FIFO_DEPTH));
   assign push       = valid_i & ready_o;
   assign pop        = (state_q == IDLE) & (count_q != '0);
   assign busy_o     = (count_q != '0) | (state_q != IDLE);
   assign send_o     = send_q;
   assign data_o     = data_q;
   assign overflow_o = ovf_q;

   // Character at the current line position: four hex digits, then CR (optional) and LF.
   always_comb begin
      nib  = 4'h0;
      char = 8'h0A;
      case (cnt_q)
         3'd0:    nib = line_q[15:12];
         3'd1:    nib = line_q[11:8];
         3'd2:    nib = line_q[7:4];
         3'd3:    nib = line_q[3:0];
         default: nib = 4'h0;
      endcase
      if (cnt_q < 3'd4) begin
         char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end else if ((cnt_q == 3'd4) && EOL_CRLF) begin
         char = 8'h0D;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      line_d   = line_q;
      cnt_d    = cnt_q;
      send_d   = 1'b0;
      data_d   = data_q;
      ovf_d    = ovf_q;

      if (valid_i && !ready_o) ovf_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (pop) begin
               line_d  = mem_q[rd_ptr_q];
               cnt_d   = 3'd0;
               state_d = LOAD;
            end
         end
         LOAD: state_d = SEND;
         SEND: begin
            if (ready_i) begin
               send_d  = 1'b1;
               data_d  = char;
               state_d = GAP;
            end
         end
         default: begin
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == LAST_IDX) ? IDLE : SEND;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && push) mem_q[wr_ptr_q] <= sample_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         line_q   <= 16'h0000;
         cnt_q    <= 3'd0;
         send_q   <= 1'b0;
         data_q   <= 8'h00;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         line_q   <= line_d;
         cnt_q    <= cnt_d;
         send_q   <= send_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_uart_hex_fmt.sv
// tb/tb_uart_hex_fmt.sv - scoreboard bench for uart_hex_fmt, CRLF and LF-only instances
// Stimulus pushes expected bytes into per-instance queues; negedge monitors pop and compare.
module tb_uart_hex_fmt;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b0;
   logic [15:0] sample_i = 16'h0000;

   logic        rdy_a, send_a, busy_a, ovf_a;
   logic [7:0]  data_a;
   logic        rdy_b, send_b, busy_b, ovf_b;
   logic [7:0]  data_b;

   always #5 clk = ~clk;

   uart_hex_fmt #(.FIFO_DEPTH(4), .EOL_CRLF(1'b1)) u_dut (
      .clk_i(clk), .reset_i(reset_i), .sample_i(sample_i), .valid_i(valid_i),
      .ready_o(rdy_a), .send_o(send_a), .data_o(data_a), .ready_i(ready_i),
      .busy_o(busy_a), .overflow_o(ovf_a)
   );

   uart_hex_fmt #(.FIFO_DEPTH(4), .EOL_CRLF(1'b0)) u_lf (
      .clk_i(clk), .reset_i(reset_i), .sample_i(sample_i), .valid_i(valid_i),
      .ready_o(rdy_b), .send_o(send_b), .data_o(data_b), .ready_i(ready_i),
      .busy_o(busy_b), .overflow_o(ovf_b)
   );

   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int         pulse_cyc[$];
   int         pulses_a = 0;
   int         pulses_b = 0;
   int         last_a = -100;
   int         last_b = -100;
   string      hex_s = "0123456789ABCDEF";

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic expect_line(input logic [15:0] s);
      logic [7:0] c;
      for (int i = 0; i < 4; i++) begin
         c = hex_s[int'((s >> (12 - 4 * i)) & 16'hF)];
         q_a.push_back(c);
         q_b.push_back(c);
      end
      q_a.push_back(8'h0D);
      q_a.push_back(8'h0A);
      q_b.push_back(8'h0A);
   endtask

   always @(negedge clk) begin
      if (!reset_i) begin
         if (send_a) begin
            if (q_a.size() == 0) begin
               n_checks++;
               $display("FAIL crlf_extra_byte: actual 0x%0h required no byte", data_a);
            end else check_eq("crlf_byte", int'(data_a), int'(q_a.pop_front()));
            if (last_a > -100) check_eq("crlf_pulse_gap_ok", int'(cyc - last_a >= 2), 1);
            pulse_cyc.push_back(cyc);
            pulses_a++;
            last_a = cyc;
         end
         if (send_b) begin
            if (q_b.size() == 0) begin
               n_checks++;
               $display("FAIL lf_extra_byte: actual 0x%0h required no byte", data_b);
            end else check_eq("lf_byte", int'(data_b), int'(q_b.pop_front()));
            if (last_b > -100) check_eq("lf_pulse_gap_ok", int'(cyc - last_b >= 2), 1);
            pulses_b++;
            last_b = cyc;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] s, input bit accept);
      sample_i = s;
      valid_i  = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      if (accept) expect_line(s);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((busy_a || busy_b || q_a.size() != 0 || q_b.size() != 0) && k < 500) begin
         tick(1);
         k++;
      end
      check_eq({name, "_drain_timeout"}, int'(k >= 500), 0);
      check_eq({name, "_crlf_left"}, q_a.size(), 0);
      check_eq({name, "_lf_left"}, q_b.size(), 0);
   endtask

   task automatic wait_pulses(input int n, input string name);
      int p0 = pulses_a;
      int k = 0;
      while (pulses_a < p0 + n && k < 100) begin
         tick(1);
         k++;
      end
      check_eq(name, pulses_a - p0, n);
   endtask

   initial begin
      int n0;
      int p1;
      int pb;

      reset_i = 1'b1;
      tick(2);
      reset_i = 1'b0;
      check_eq("rst_send", int'(send_a), 0);
      check_eq("rst_data", int'(data_a), 0);
      check_eq("rst_ready", int'(rdy_a), 1);
      check_eq("rst_busy", int'(busy_a), 0);
      check_eq("rst_ovf", int'(ovf_a), 0);

      // 0x1234: latency, pulse spacing, busy fall
      ready_i = 1'b1;
      pulse_cyc.delete();
      push(16'h1234, 1'b1);
      n0 = cyc;
      while (cyc < n0 + 13) tick(1);
      check_eq("busy_last_gap", int'(busy_a), 1);
      tick(1);
      check_eq("busy_after_line", int'(busy_a), 0);
      check_eq("pulse_count", pulse_cyc.size(), 6);
      if (pulse_cyc.size() == 6) begin
         check_eq("first_pulse_cycle", pulse_cyc[0] - n0, 3);
         check_eq("last_pulse_cycle", pulse_cyc[5] - n0, 13);
      end
      wait_idle("l1234");

      push(16'hABCF, 1'b1);
      wait_idle("labcf");

      // overflow: stall output, six pushes into a four-deep FIFO plus line register
      ready_i = 1'b0;
      push(16'hC001, 1'b1);
      push(16'hC002, 1'b1);
      push(16'hC003, 1'b1);
      push(16'hC004, 1'b1);
      check_eq("ready_after_4", int'(rdy_a), 1);
      push(16'hC005, 1'b1);
      check_eq("ready_after_5", int'(rdy_a), 0);
      check_eq("ovf_before_drop", int'(ovf_a), 0);
      push(16'hDEAD, 1'b0);
      check_eq("ovf_crlf", int'(ovf_a), 1);
      check_eq("ovf_lf", int'(ovf_b), 1);
      ready_i = 1'b1;
      wait_idle("overflow");

      // stall after second byte
      push(16'h5A3C, 1'b1);
      wait_pulses(2, "stall_pre");
      ready_i = 1'b0;
      p1 = pulses_a;
      pb = pulses_b;
      tick(10);
      check_eq("stall_no_pulse_crlf", pulses_a - p1, 0);
      check_eq("stall_no_pulse_lf", pulses_b - pb, 0);
      ready_i = 1'b1;
      wait_idle("stall");
      check_eq("ovf_sticky", int'(ovf_a), 1);

      // reset mid-line
      push(16'h7E11, 1'b1);
      wait_pulses(2, "reset_pre");
      reset_i = 1'b1;
      tick(1);
      reset_i = 1'b0;
      q_a.delete();
      q_b.delete();
      last_a = -100;
      last_b = -100;
      check_eq("mid_rst_send", int'(send_a), 0);
      check_eq("mid_rst_ready", int'(rdy_a), 1);
      check_eq("mid_rst_ovf", int'(ovf_a), 0);
      check_eq("mid_rst_data", int'(data_a), 0);
      p1 = pulses_a;
      tick(6);
      check_eq("mid_rst_silent", pulses_a - p1, 0);
      push(16'h00FF, 1'b1);
      wait_idle("l00ff");

      // push coinciding with an IDLE pop while two entries are queued
      push(16'h1111, 1'b1);
      n0 = cyc;
      push(16'h2222, 1'b1);
      push(16'h3333, 1'b1);
      while (cyc < n0 + 14) tick(1);
      push(16'h4444, 1'b1);
      ready_i = 1'b0;
      push(16'h5555, 1'b1);
      check_eq("occ_ready_3", int'(rdy_a), 1);
      push(16'h6666, 1'b1);
      check_eq("occ_ready_4", int'(rdy_a), 0);
      ready_i = 1'b1;
      wait_idle("occupancy");

      // pointer wrap across several bursts
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 4; i++) push({4'(b), 4'(i + 9), 8'hE7}, 1'b1);
         wait_idle("wrap");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
